// File: rtl/apb_master_ctrl_pkg.sv
// Shared FSM state type and width helpers for the APB master controller.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DATA_W_DEF  = 32;
    localparam int NUM_SLV_DEF = 4;
    localparam int STRB_W      = DATA_W_DEF / 8;
    localparam int SEL_W       = (NUM_SLV_DEF > 1) ? $clog2(NUM_SLV_DEF) : 1;

    // Index/counter width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_ctrl_decode.sv
// Combinational address decoder: address -> slave index, one-hot select and
// a decode error when the index falls beyond the populated slaves.
module apb_slave_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int NUM_SLV   = NUM_SLV_DEF,
    parameter int SLV_SHIFT = 6,
    parameter int SEL_W_P   = SEL_W
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [SEL_W_P-1:0] idx_o,
    output logic [NUM_SLV-1:0] psel_o,
    output logic               dec_err_o
);

    localparam logic [ADDR_W:0] SLOTS = (ADDR_W + 1)'(NUM_SLV);

    logic [ADDR_W-1:0] slot;

    assign slot      = addr_i >> SLV_SHIFT;
    assign dec_err_o = ({1'b0, slot} >= SLOTS);
    assign idx_o     = SEL_W_P'(slot);

    always_comb begin
        psel_o = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            psel_o[i] = !dec_err_o && (slot == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: valid/ready command in, registered APB phases out, one-cycle response pulse.
//   state  | meaning
//   IDLE   | bus quiet, cmd_ready high; decode errors answered from here
//   SETUP  | psel high, penable low, exactly one cycle
//   ACCESS | penable high, waiting on the selected slave's pready or the timeout
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8 * STRB_W,
    parameter int NUM_SLV   = NUM_SLV_DEF,
    parameter int SLV_SHIFT = 6,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W/8-1:0]       cmd_strb,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [ADDR_W-1:0]         paddr,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int IDX_W = idx_width(NUM_SLV);
    localparam int CNT_W = idx_width(TIMEOUT + 1);

    apb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic [IDX_W-1:0]    dec_idx;
    logic [NUM_SLV-1:0]  dec_psel;
    logic                dec_err;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic                load;

    apb_slave_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_SLV   (NUM_SLV),
        .SLV_SHIFT (SLV_SHIFT),
        .SEL_W_P   (IDX_W)
    ) u_decode (
        .addr_i    (cmd_addr),
        .idx_o     (dec_idx),
        .psel_o    (dec_psel),
        .dec_err_o (dec_err)
    );

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        cmd_ready     = 1'b0;
        load          = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                psel_d    = '0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    if (dec_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
                    // A decode-error command waits for IDLE so its response
                    // cannot collide with the one being returned now.
                    cmd_ready   = !dec_err;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                    load        = cmd_valid && !dec_err;
                end else if (TIMEOUT > 0 && int'(cnt_q) + 1 == TIMEOUT) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d   = SETUP;
            cnt_d     = '0;
            idx_d     = dec_idx;
            psel_d    = dec_psel;
            penable_d = 1'b0;
            paddr_d   = cmd_addr;
            pwrite_d  = cmd_write;
            pwdata_d  = cmd_write ? cmd_wdata : '0;
            pstrb_d   = cmd_write ? cmd_strb : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: three slaves, 8-cycle timeout,
// behavioural slave responder and a transaction-level expectation model.
module tb_apb_master_ctrl;

    localparam int NSLV = 3;
    localparam int TMO  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [7:0]        cmd_addr = '0;
    logic [31:0]       cmd_wdata = '0;
    logic [3:0]        cmd_strb = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [7:0]        paddr;
    logic [NSLV-1:0]   psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [NSLV*32-1:0] prdata = '0;
    logic [NSLV-1:0]   pready = '0;
    logic [NSLV-1:0]   pslverr = '0;

    int          errors = 0;
    int          checks = 0;
    int          cfg_waits = 0;
    bit          cfg_err = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          acc_n = 0;

    typedef struct {
        logic        rdy0;
        logic        rdy_s;
        logic [2:0]  sel_s;
        logic        en_s;
        logic [7:0]  addr_s;
        logic        wr_s;
        logic [31:0] wd_s;
        logic [3:0]  st_s;
        int          n_en;
        int          lat;
        logic        stable;
        logic        got;
        logic        err;
        logic        to;
        logic [31:0] rd;
        logic [2:0]  sel_r;
        logic        en_r;
        logic [7:0]  addr_r;
        logic        v_after;
    } obs_t;

    typedef struct {
        bit          dec;
        logic [2:0]  sel;
        logic [31:0] wd;
        logic [3:0]  st;
        int          n_en;
        int          lat;
        logic        err;
        logic        to;
        logic [31:0] rd;
    } exp_t;

    apb_master_ctrl #(
        .ADDR_W    (8),
        .DATA_W    (32),
        .NUM_SLV   (NSLV),
        .SLV_SHIFT (6),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    // Slave responder: unselected slaves drive noise; the selected slave raises
    // pready after cfg_waits ACCESS cycles.
    always @(posedge clk) begin
        #1;
        pready  = 3'($urandom);
        pslverr = 3'($urandom);
        for (int i = 0; i < NSLV; i++) prdata[i*32 +: 32] = $urandom;
        if (penable && psel != '0) begin
            for (int i = 0; i < NSLV; i++) begin
                if (psel[i]) begin
                    pready[i]          = (acc_n >= cfg_waits);
                    pslverr[i]         = cfg_err;
                    prdata[i*32 +: 32] = cfg_rdata;
                end
            end
            acc_n++;
        end else begin
            acc_n = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t model(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                                   input logic [3:0] st, input int waits, input bit serr,
                                   input logic [31:0] rd);
        exp_t e;
        int   slv;
        slv   = int'(a) / 64;
        e.dec = (slv >= NSLV);
        e.sel = e.dec ? 3'b000 : 3'(1 << slv);
        e.wd  = wr ? wd : 32'h0;
        e.st  = wr ? st : 4'h0;
        if (e.dec) begin
            e.n_en = 0; e.err = 1'b1; e.to = 1'b0; e.rd = '0;
        end else if (waits >= TMO) begin
            e.n_en = TMO; e.err = 1'b1; e.to = 1'b1; e.rd = '0;
        end else begin
            e.n_en = waits + 1; e.err = serr; e.to = 1'b0;
            e.rd   = (!wr && !serr) ? rd : 32'h0;
        end
        e.lat = e.dec ? 1 : e.n_en + 2;
        return e;
    endfunction

    // Drives one command from IDLE and records what the bus and response did.
    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int waits, input bit serr,
                        input logic [31:0] rd, output obs_t o);
        o = '{default: '0};
        cfg_waits = waits; cfg_err = serr; cfg_rdata = rd;
        @(negedge clk);
        cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = st; cmd_valid = 1'b1;
        o.rdy0 = cmd_ready;
        @(negedge clk);
        cmd_valid = 1'b0;
        o.rdy_s = cmd_ready; o.sel_s = psel; o.en_s = penable; o.addr_s = paddr;
        o.wr_s = pwrite; o.wd_s = pwdata; o.st_s = pstrb;
        o.lat = 1; o.stable = 1'b1;
        while (!rsp_valid && o.lat < 40) begin
            @(negedge clk);
            o.lat++;
            if (!rsp_valid) begin
                if (penable) o.n_en++;
                if (psel !== o.sel_s || paddr !== o.addr_s || pwdata !== o.wd_s ||
                    pstrb !== o.st_s || pwrite !== o.wr_s || cmd_ready !== 1'b0 && !penable)
                    o.stable = 1'b0;
            end
        end
        o.got = rsp_valid; o.err = rsp_err; o.to = rsp_timeout; o.rd = rsp_rdata;
        o.sel_r = psel; o.en_r = penable; o.addr_r = paddr;
        @(negedge clk);
        o.v_after = rsp_valid;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: psel=%b en=%b paddr=%h rsp_valid=%b want all zero", psel, penable, paddr, rsp_valid);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        obs_t o;
        xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h5555AAAA, o);
        checks++; if (o.rdy0 !== 1'b1) begin errors++; $display("FAIL write_ready_idle: got %b want 1", o.rdy0); end
        checks++; if (o.sel_s !== 3'b001 || o.en_s !== 1'b0) begin errors++; $display("FAIL write_setup: psel=%b en=%b want 001/0", o.sel_s, o.en_s); end
        checks++; if (o.rdy_s !== 1'b0) begin errors++; $display("FAIL write_ready_setup: got %b want 0", o.rdy_s); end
        checks++; if (o.addr_s !== 8'h04 || o.wr_s !== 1'b1) begin errors++; $display("FAIL write_addr: paddr=%h pwrite=%b want 04/1", o.addr_s, o.wr_s); end
        checks++; if (o.wd_s !== 32'hDEADBEEF || o.st_s !== 4'hF) begin errors++; $display("FAIL write_data: pwdata=%h pstrb=%h want deadbeef/f", o.wd_s, o.st_s); end
        checks++; if (o.n_en !== 1 || o.lat !== 3) begin errors++; $display("FAIL write_latency: penable=%0d lat=%0d want 1/3", o.n_en, o.lat); end
        checks++; if (o.got !== 1'b1 || o.err !== 1'b0 || o.rd !== 32'h0) begin errors++; $display("FAIL write_rsp: valid=%b err=%b rdata=%h want 1/0/0", o.got, o.err, o.rd); end
        checks++; if (o.v_after !== 1'b0) begin errors++; $display("FAIL write_pulse: rsp_valid stayed %b want 0", o.v_after); end
    endtask

    task automatic test_wait_read;
        obs_t o;
        xfer(1'b0, 8'h48, $urandom, 4'($urandom), 3, 1'b0, 32'h12345678, o);
        checks++; if (o.sel_s !== 3'b010) begin errors++; $display("FAIL rdwait_psel: got %b want 010", o.sel_s); end
        checks++; if (o.wd_s !== 32'h0 || o.st_s !== 4'h0 || o.wr_s !== 1'b0) begin errors++; $display("FAIL rdwait_wdata: pwdata=%h pstrb=%h pwrite=%b want 0", o.wd_s, o.st_s, o.wr_s); end
        checks++; if (o.n_en !== 4) begin errors++; $display("FAIL rdwait_penable: got %0d cycles want 4", o.n_en); end
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL rdwait_stable: bus moved during ACCESS (got %b want 1)", o.stable); end
        checks++; if (o.rd !== 32'h12345678 || o.err !== 1'b0) begin errors++; $display("FAIL rdwait_rdata: got %h err=%b want 12345678/0", o.rd, o.err); end
        checks++; if (o.addr_r !== 8'h48) begin errors++; $display("FAIL rdwait_hold: paddr=%h want 48", o.addr_r); end
    endtask

    task automatic test_pslverr;
        obs_t o;
        xfer(1'b0, 8'h8C, '0, '0, 1, 1'b1, 32'hCAFEF00D, o);
        checks++; if (o.sel_s !== 3'b100 || o.n_en !== 2) begin errors++; $display("FAIL slverr_bus: psel=%b penable=%0d want 100/2", o.sel_s, o.n_en); end
        checks++; if (o.err !== 1'b1 || o.to !== 1'b0 || o.rd !== 32'h0) begin errors++; $display("FAIL slverr_rsp: err=%b to=%b rdata=%h want 1/0/0", o.err, o.to, o.rd); end
    endtask

    task automatic test_timeout;
        obs_t o;
        xfer(1'b1, 8'h30, 32'hA5A5A5A5, 4'h3, 100, 1'b0, '0, o);
        checks++; if (o.n_en !== TMO || o.lat !== TMO + 2) begin errors++; $display("FAIL timeout_len: penable=%0d lat=%0d want %0d/%0d", o.n_en, o.lat, TMO, TMO + 2); end
        checks++; if (o.err !== 1'b1 || o.to !== 1'b1 || o.rd !== 32'h0) begin errors++; $display("FAIL timeout_rsp: err=%b to=%b rdata=%h want 1/1/0", o.err, o.to, o.rd); end
        checks++; if (o.sel_r !== 3'b000 || o.en_r !== 1'b0) begin errors++; $display("FAIL timeout_drop: psel=%b en=%b want 000/0", o.sel_r, o.en_r); end
        xfer(1'b0, 8'h70, '0, '0, TMO - 1, 1'b0, 32'h0BADF00D, o);
        checks++; if (o.n_en !== TMO || o.err !== 1'b0 || o.to !== 1'b0 || o.rd !== 32'h0BADF00D) begin
            errors++; $display("FAIL timeout_edge: penable=%0d err=%b to=%b rdata=%h want %0d/0/0/0badf00d", o.n_en, o.err, o.to, o.rd, TMO);
        end
    endtask

    task automatic test_decode_err;
        obs_t o;
        xfer(1'b1, 8'hC0, 32'h11111111, 4'hF, 0, 1'b0, '0, o);
        checks++; if (o.sel_s !== 3'b000 || o.en_s !== 1'b0) begin errors++; $display("FAIL decerr_psel: psel=%b en=%b want 000/0", o.sel_s, o.en_s); end
        checks++; if (o.lat !== 1 || o.err !== 1'b1 || o.to !== 1'b0) begin errors++; $display("FAIL decerr_rsp: lat=%0d err=%b to=%b want 1/1/0", o.lat, o.err, o.to); end
        checks++; if (o.rdy_s !== 1'b1) begin errors++; $display("FAIL decerr_ready: got %b want 1", o.rdy_s); end
    endtask

    task automatic test_back_to_back;
        cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = '0;
        @(negedge clk);
        cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'h01020304; cmd_strb = 4'h5; cmd_valid = 1'b1;
        @(negedge clk);
        checks++; if (psel !== 3'b001 || penable !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_setup1: psel=%b en=%b rdy=%b want 001/0/0", psel, penable, cmd_ready); end
        cmd_addr = 8'h20; cmd_wdata = 32'hF0E0D0C0; cmd_strb = 4'hA;
        @(negedge clk);
        checks++; if (penable !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_access1: en=%b rdy=%b want 1/1", penable, cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_rsp1: valid=%b err=%b want 1/0", rsp_valid, rsp_err); end
        checks++; if (psel !== 3'b001 || penable !== 1'b0 || paddr !== 8'h20 || pwdata !== 32'hF0E0D0C0 || pstrb !== 4'hA) begin
            errors++; $display("FAIL b2b_setup2: psel=%b en=%b paddr=%h pwdata=%h pstrb=%h want 001/0/20/f0e0d0c0/a", psel, penable, paddr, pwdata, pstrb);
        end
        @(negedge clk);
        checks++; if (penable !== 1'b1 || psel !== 3'b001) begin errors++; $display("FAIL b2b_access2: en=%b psel=%b want 1/001", penable, psel); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || psel !== 3'b000 || penable !== 1'b0) begin errors++; $display("FAIL b2b_rsp2: valid=%b psel=%b en=%b want 1/000/0", rsp_valid, psel, penable); end
    endtask

    task automatic test_random;
        obs_t o;
        exp_t e;
        bit wr, serr;
        logic [7:0] a;
        logic [31:0] wd, rd;
        logic [3:0] st;
        int waits;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom); a = 8'($urandom); wd = $urandom; st = 4'($urandom);
            waits = $urandom_range(0, 9); serr = ($urandom_range(0, 3) == 0); rd = $urandom;
            e = model(wr, a, wd, st, waits, serr, rd);
            xfer(wr, a, wd, st, waits, serr, rd, o);
            checks++; if (o.got !== 1'b1 || o.lat !== e.lat) begin errors++; $display("FAIL rnd%0d_latency: valid=%b lat=%0d want 1/%0d", n, o.got, o.lat, e.lat); end
            checks++; if (o.sel_s !== e.sel || o.en_s !== 1'b0) begin errors++; $display("FAIL rnd%0d_psel: psel=%b en=%b want %b/0", n, o.sel_s, o.en_s, e.sel); end
            checks++; if (o.err !== e.err || o.to !== e.to || o.rd !== e.rd) begin
                errors++; $display("FAIL rnd%0d_rsp: err=%b to=%b rdata=%h want %b/%b/%h", n, o.err, o.to, o.rd, e.err, e.to, e.rd);
            end
            checks++; if (o.sel_r !== 3'b000 || o.en_r !== 1'b0 || o.v_after !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_end: psel=%b en=%b next_valid=%b want 000/0/0", n, o.sel_r, o.en_r, o.v_after);
            end
            if (!e.dec) begin
                checks++; if (o.addr_s !== a || o.wr_s !== wr || o.wd_s !== e.wd || o.st_s !== e.st) begin
                    errors++; $display("FAIL rnd%0d_bus: paddr=%h pwrite=%b pwdata=%h pstrb=%h want %h/%b/%h/%h", n, o.addr_s, o.wr_s, o.wd_s, o.st_s, a, wr, e.wd, e.st);
                end
                checks++; if (o.n_en !== e.n_en || o.stable !== 1'b1 || o.addr_r !== a) begin
                    errors++; $display("FAIL rnd%0d_access: penable=%0d stable=%b paddr_after=%h want %0d/1/%h", n, o.n_en, o.stable, o.addr_r, e.n_en, a);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        cfg_waits = 100; cfg_err = 1'b0;
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 8'h80; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (penable !== 1'b1 || psel !== 3'b100) begin errors++; $display("FAIL rstmid_access: en=%b psel=%b want 1/100", penable, psel); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (psel !== 3'b000 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: psel=%b en=%b valid=%b want 000/0/0", psel, penable, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || psel !== 3'b000) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_quiet: %0d cycles with response/select, want 0", stray); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wait_read();
        test_back_to_back();
        test_pslverr();
        test_timeout();
        test_decode_err();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
